// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding async_transmitter: launches one byte per frame when the transmitter is idle.
// Build option UART_TX_FIFO_FLUSH_EN adds a one-cycle flush input that empties the FIFO.
module uart_tx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int BUSY_TMO = 1023
) (
  input  logic              clk,
  input  logic              reset,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [9:0]        tmo_cnt;
  logic              clr;
  logic              push;
  logic              pop;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full & ~clr;
  assign pop   = (state == IDLE) & ~empty & ~tx_busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Flush wins over both pointers; a same-cycle pop still loads tx_data below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en & full & ~clr) overflow <= 1'b1;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        if (push & ~pop)      count <= count + (ADDR_W+1)'(1);
        else if (pop & ~push) count <= count - (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      tmo_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never acknowledges costs the byte; no retry.
          if (tx_busy)                          state   <= WAIT_DONE;
          else if (tmo_cnt == 10'(BUSY_TMO))    state   <= IDLE;
          else                                  tmo_cnt <= tmo_cnt + 10'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/random bench for uart_tx_fifo with a behavioural transmitter and expected-byte queue.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_busy, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic       flush;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .reset(reset),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data)
  );

  int tests = 0;
  int fails = 0;

  // Transmitter model: busy for frame_len cycles starting the cycle after tx_start.
  int   frame_len = 20;
  int   busy_left = 0;
  logic hold_busy = 1'b0;
  logic deaf = 1'b0;
  assign tx_busy = hold_busy | (busy_left > 0);

  always @(posedge clk) begin
    if (busy_left > 0)                busy_left <= busy_left - 1;
    else if (tx_start && !deaf)       busy_left <= frame_len;
  end

  int         cyc = 0;
  logic [7:0] launched[$];
  int         ltime[$];
  logic [7:0] last_launched = 8'h00;
  logic       chk_stable = 1'b1;
  int         stable_err = 0;
  int         busy_start_err = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      launched.push_back(tx_data);
      ltime.push_back(cyc);
      last_launched = tx_data;
      if (tx_busy) busy_start_err++;
    end else if (tx_busy && chk_stable && tx_data !== last_launched) begin
      stable_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k = 0;
    while (launched.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("launch_wait", 32'(launched.size() >= n), 1);
  endtask

  task automatic wait_idle_tx(input int budget);
    int k = 0;
    while (tx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("busy_fall_wait", 32'(tx_busy), 0);
  endtask

  task automatic check_seq(input string tag, input int base);
    check({tag, "_n"}, launched.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < launched.size(); i++)
      check(tag, launched[base+i], exp_q[i]);
  endtask

  initial begin
    int base;
    logic [7:0] b;
    reset = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Single byte latency
    push(8'hA5);
    check("t1_start_early", tx_start, 0);
    check("t1_count1", count, 1);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_empty", empty, 1);
    @(negedge clk);
    check("t1_pulse_len", tx_start, 0);
    repeat (3) @(negedge clk);
    wait_idle_tx(100);
    repeat (2) @(negedge clk);

    // Fill while transmitter held busy, overflow, then ordered drain
    frame_len = 30;
    hold_busy = 1'b1;
    base = launched.size();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    check("t2_full", full, 1);
    check("t2_count", count, 16);
    check("t2_ovf_pre", overflow, 0);
    push(8'hFF);
    check("t2_ovf", overflow, 1);
    check("t2_count_ovf", count, 16);
    hold_busy = 1'b0;
    wait_launches(base + 16, 2000);
    wait_idle_tx(200);
    repeat (5) @(negedge clk);
    check_seq("t2_order", base);
    check("t2_empty", empty, 1);
    check("t2_ovf_sticky", overflow, 1);

    // Long frames, burst of 5 random bytes
    frame_len = 10417;
    base = launched.size();
    exp_q.delete();
    stable_err = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push(b);
    end
    wait_launches(base + 5, 60000);
    wait_idle_tx(11000);
    check_seq("t3_order", base);
    check("t3_stable", stable_err, 0);
    check("t3_start_busy", busy_start_err, 0);

    // Busy never rises: timeout then next byte launches
    frame_len = 4;
    deaf = 1'b1;
    base = launched.size();
    push(8'h11);
    push(8'h22);
    wait_launches(base + 2, 3000);
    if (launched.size() >= base + 2) begin
      check("t4_gap_min", 32'(ltime[base+1] - ltime[base] >= 1024), 1);
      check("t4_gap_max", 32'(ltime[base+1] - ltime[base] <= 1028), 1);
      check("t4_byte2", launched[base+1], 8'h22);
    end
    repeat (1100) @(negedge clk);
    deaf = 1'b0;

    // 40 random bytes pushed in bursts while draining (pointer wrap)
    base = launched.size();
    exp_q.delete();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 10; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
      wait_launches(base + 10 * (g + 1), 500);
    end
    wait_idle_tx(100);
    repeat (5) @(negedge clk);
    check_seq("t4_wrap", base);
    check("t4_empty", empty, 1);

    // Reset during WAIT_DONE with 3 bytes queued
    frame_len = 200;
    base = launched.size();
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    repeat (20) @(negedge clk);
    check("t5_pre_count", count, 3);
    check("t5_pre_busy", tx_busy, 1);
    chk_stable = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_count", count, 0);
    check("t5_start", tx_start, 0);
    check("t5_ovf", overflow, 0);
    check("t5_empty", empty, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(8'h3C);
    check("t5_held", launched.size() - base, 1);
    wait_idle_tx(300);
    wait_launches(base + 2, 50);
    if (launched.size() >= base + 2) check("t5_byte", launched[base+1], 8'h3C);
    check("t5_start_busy", busy_start_err, 0);
    chk_stable = 1'b1;
    wait_idle_tx(300);
    repeat (5) @(negedge clk);
    check("t5_total", launched.size() - base, 2);

`ifdef UART_TX_FIFO_FLUSH_EN
    // Flush with 6 queued and a same-cycle push
    frame_len = 100;
    base = launched.size();
    for (int i = 0; i < 7; i++) push(8'($urandom));
    repeat (5) @(negedge clk);
    check("t6_pre_count", count, 6);
    flush = 1'b1;
    push(8'h77);
    flush = 1'b0;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_ovf", overflow, 0);
    wait_idle_tx(300);
    repeat (50) @(negedge clk);
    check("t6_launches", launched.size() - base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
